if_id_queue: RTL and testbench

- Decoupling queue between the fetch stage and the decode stage; replaces the plain IF/ID register.
- Captures each fetched (already decompressed) instruction with its PC, branch tag and decompress-fail flag into a small FIFO.
- Presents the head entry to decode with a valid/ready handshake.
- Absorbs decode back-pressure, filters fetch bubbles and honours pipeline flushes.

---
 rtl/if_id_queue_pkg.sv | 22 ++
 rtl/if_id_queue_if.sv | 34 +++
 rtl/if_id_queue_sync_fifo_mem.sv | 25 ++
 rtl/if_id_queue.sv | 100 ++++++++++
 tb/tb_if_id_queue.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode types for the IF/ID decoupling queue.
package if_id_queue_pkg;

  typedef logic [31:0] instruction_type;

  localparam instruction_type INSTR_BUBBLE = 32'h0000_0000;
  localparam instruction_type INSTR_END    = 32'h0000_1111;

  typedef struct packed {
    instruction_type instr;
    logic [31:0]     pc;
    logic            is_branch;
    logic            illegal;
  } if_id_entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } queue_state_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side push port and decode-side pop port of the IF/ID queue.
interface if_id_queue_if #(parameter int DEPTH = 4);
  import if_id_queue_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic            in_valid;
  instruction_type in_instr;
  logic [31:0]     in_pc;
  logic            in_is_branch;
  logic            in_decompress_failed;
  logic            in_ready;
  logic            flush;
  logic            out_valid;
  instruction_type out_instr;
  logic [31:0]     out_pc;
  logic            out_is_branch;
  logic            out_illegal;
  logic            out_ready;
  logic [PTR_W:0]  count;

  modport master (
    output in_valid, in_instr, in_pc, in_is_branch, in_decompress_failed,
    output flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_is_branch, out_illegal, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_is_branch, in_decompress_failed,
    input  flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_is_branch, out_illegal, count
  );

endinterface

// File: rtl/if_id_queue_sync_fifo_mem.sv
// Entry storage for the IF/ID queue: registered write port, asynchronous read.
module sync_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are deliberately left unreset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_id_queue.sv
// Decoupling FIFO between fetch and decode: drops bubbles, absorbs stalls, honours flush.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  if_id_queue_if.slave q
);

  localparam int             PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W:0] MAX_COUNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   w_nextCount;
  queue_state_t     r_state;
  logic             w_push;
  logic             w_pop;
  logic             w_inReady;
  logic             w_outValid;
  if_id_entry_t     w_wrEntry;
  if_id_entry_t     w_headEntry;

  assign w_inReady  = (r_state != FULL);
  assign w_outValid = (r_state != EMPTY);
  assign w_push     = q.in_valid && w_inReady && !q.flush && (q.in_instr != INSTR_BUBBLE);
  assign w_pop      = w_outValid && q.out_ready && !q.flush;

  assign w_wrEntry = '{instr:     q.in_instr,
                       pc:        q.in_pc,
                       is_branch: q.in_is_branch,
                       illegal:   q.in_decompress_failed};

  always_comb begin
    w_nextCount = r_count;
    if (q.flush) begin
      w_nextCount = '0;
    end else if (w_push && !w_pop) begin
      w_nextCount = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_nextCount = r_count - 1'b1;
    end
  end

  // State tracks the next occupancy so in_ready/out_valid decode straight from a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      r_state <= EMPTY;
    end else begin
      r_count <= w_nextCount;
      if (q.flush) begin
        r_rdPtr <= '0;
        r_wrPtr <= '0;
      end else begin
        if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
        if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_nextCount == '0) begin
        r_state <= EMPTY;
      end else if (w_nextCount == MAX_COUNT) begin
        r_state <= FULL;
      end else begin
        r_state <= PARTIAL;
      end
    end
  end

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(if_id_entry_t))
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wrPtr),
    .i_wdata (w_wrEntry),
    .i_raddr (r_rdPtr),
    .o_rdata (w_headEntry)
  );

  assign q.in_ready      = w_inReady;
  assign q.out_valid     = w_outValid;
  assign q.out_instr     = w_outValid ? w_headEntry.instr : INSTR_BUBBLE;
  assign q.out_pc        = w_outValid ? w_headEntry.pc : 32'h0;
  assign q.out_is_branch = w_outValid && w_headEntry.is_branch;
  assign q.out_illegal   = w_outValid && w_headEntry.illegal;
  assign q.count         = r_count;

  stateMatchesCount: assert property (@(posedge clk) disable iff (reset)
    ((r_state == EMPTY) == (r_count == '0)) && ((r_state == FULL) == (r_count == MAX_COUNT)));

  noPushWhenFull: assert property (@(posedge clk) disable iff (reset)
    !(w_push && (r_count == MAX_COUNT)));

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: vector table, hand sequences, randomized model run.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] TAG = 32'hC000_0000;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  if_id_queue_if #(.DEPTH(DEPTH)) qIf();

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (qIf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1);
  end

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        br;
    logic        ill;
    logic        flush;
    logic        outReady;
    logic        expValid;
    logic [31:0] expInstr;
    logic [31:0] expPc;
    logic        expBr;
    logic        expIll;
    int          expCount;
    logic        expInReady;
  } vector_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        br;
    logic        ill;
  } entry_t;

  vector_t vecs[$];
  entry_t  model[$];

  function automatic void addVec(logic v, logic [31:0] instr, logic [31:0] pc, logic fl,
                                 logic orr, logic ev, logic [31:0] ei, logic [31:0] ep,
                                 int ec, logic er, logic br = 1'b0, logic ill = 1'b0,
                                 logic ebr = 1'b0, logic eill = 1'b0);
    vector_t t;
    t.valid = v;      t.instr = instr;  t.pc = pc;     t.br = br;     t.ill = ill;
    t.flush = fl;     t.outReady = orr;
    t.expValid = ev;  t.expInstr = ei;  t.expPc = ep;  t.expBr = ebr; t.expIll = eill;
    t.expCount = ec;  t.expInReady = er;
    vecs.push_back(t);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic driveInputs(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                             input logic br, input logic ill, input logic fl, input logic orr);
    qIf.in_valid             = v;
    qIf.in_instr             = instr;
    qIf.in_pc                = pc;
    qIf.in_is_branch         = br;
    qIf.in_decompress_failed = ill;
    qIf.flush                = fl;
    qIf.out_ready            = orr;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic br, input logic ill, input logic fl, input logic orr);
    driveInputs(v, instr, pc, br, ill, fl, orr);
    @(posedge clk);
    #1;
  endtask

  // Queue semantics straight from the rules: flush clears, pop from front, push if room was there before the edge.
  task automatic modelStep(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                           input logic br, input logic ill, input logic fl, input logic orr);
    entry_t e;
    bit     doPop;
    bit     doPush;
    if (fl) begin
      model.delete();
    end else begin
      doPop  = (model.size() > 0) && orr;
      doPush = v && (model.size() < DEPTH) && (instr != 32'h0);
      if (doPop) model.delete(0);
      if (doPush) begin
        e.instr = instr; e.pc = pc; e.br = br; e.ill = ill;
        model.push_back(e);
      end
    end
  endtask

  task automatic checkAgainstModel(input string tag);
    logic ev;
    ev = (model.size() != 0);
    checkOutput({tag, ".valid"},   32'(qIf.out_valid),     32'(ev));
    checkOutput({tag, ".instr"},   qIf.out_instr,          ev ? model[0].instr : 32'h0);
    checkOutput({tag, ".pc"},      qIf.out_pc,             ev ? model[0].pc : 32'h0);
    checkOutput({tag, ".branch"},  32'(qIf.out_is_branch), ev ? 32'(model[0].br) : 32'h0);
    checkOutput({tag, ".illegal"}, 32'(qIf.out_illegal),   ev ? 32'(model[0].ill) : 32'h0);
    checkOutput({tag, ".count"},   32'(qIf.count),         32'(model.size()));
    checkOutput({tag, ".inReady"}, 32'(qIf.in_ready),      32'(model.size() < DEPTH));
  endtask

  initial begin
    reset = 1'b1;
    driveInputs(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    reset = 1'b0;

    checkOutput("reset.valid",   32'(qIf.out_valid),     32'h0);
    checkOutput("reset.instr",   qIf.out_instr,          32'h0);
    checkOutput("reset.pc",      qIf.out_pc,             32'h0);
    checkOutput("reset.branch",  32'(qIf.out_is_branch), 32'h0);
    checkOutput("reset.illegal", 32'(qIf.out_illegal),   32'h0);
    checkOutput("reset.count",   32'(qIf.count),         32'h0);
    checkOutput("reset.inReady", 32'(qIf.in_ready),      32'h1);

    // single push then pop
    addVec(1, 32'h00500093, 32'h0, 0, 0, 1, 32'h00500093, 32'h0, 1, 1);
    addVec(0, 32'h0,        32'h0, 0, 1, 0, 32'h0,        32'h0, 0, 1);
    // fill past capacity with decode stalled
    addVec(1, TAG | 32'h00, 32'h00, 0, 0, 1, TAG | 32'h00, 32'h00, 1, 1);
    addVec(1, TAG | 32'h04, 32'h04, 0, 0, 1, TAG | 32'h00, 32'h00, 2, 1);
    addVec(1, TAG | 32'h08, 32'h08, 0, 0, 1, TAG | 32'h00, 32'h00, 3, 1);
    addVec(1, TAG | 32'h0c, 32'h0c, 0, 0, 1, TAG | 32'h00, 32'h00, 4, 0);
    addVec(1, TAG | 32'h10, 32'h10, 0, 0, 1, TAG | 32'h00, 32'h00, 4, 0);
    addVec(0, 32'h0,        32'h0,  0, 1, 1, TAG | 32'h04, 32'h04, 3, 1);
    addVec(0, 32'h0,        32'h0,  0, 1, 1, TAG | 32'h08, 32'h08, 2, 1);
    addVec(0, 32'h0,        32'h0,  0, 1, 1, TAG | 32'h0c, 32'h0c, 1, 1);
    addVec(0, 32'h0,        32'h0,  0, 1, 0, 32'h0,        32'h0,  0, 1);
    // bubbles interleaved with real instructions
    addVec(1, 32'h0,        32'h1c, 0, 0, 0, 32'h0,        32'h0,  0, 1);
    addVec(1, TAG | 32'h20, 32'h20, 0, 0, 1, TAG | 32'h20, 32'h20, 1, 1);
    addVec(1, 32'h0,        32'h22, 0, 0, 1, TAG | 32'h20, 32'h20, 1, 1);
    addVec(1, TAG | 32'h24, 32'h24, 0, 0, 1, TAG | 32'h20, 32'h20, 2, 1);
    addVec(1, 32'h0,        32'h26, 0, 0, 1, TAG | 32'h20, 32'h20, 2, 1);
    addVec(0, 32'h0,        32'h0,  0, 1, 1, TAG | 32'h24, 32'h24, 1, 1);
    addVec(0, 32'h0,        32'h0,  0, 1, 0, 32'h0,        32'h0,  0, 1);
    // flush beats a concurrent push and pop
    addVec(1, TAG | 32'h30, 32'h30, 0, 0, 1, TAG | 32'h30, 32'h30, 1, 1);
    addVec(1, TAG | 32'h34, 32'h34, 0, 0, 1, TAG | 32'h30, 32'h30, 2, 1);
    addVec(1, TAG | 32'h38, 32'h38, 0, 0, 1, TAG | 32'h30, 32'h30, 3, 1);
    addVec(1, TAG | 32'h3c, 32'h3c, 1, 1, 0, 32'h0,        32'h0,  0, 1);
    addVec(1, TAG | 32'h40, 32'h40, 0, 0, 1, TAG | 32'h40, 32'h40, 1, 1, 1, 1, 1, 1);
    addVec(0, 32'h0,        32'h0,  0, 1, 0, 32'h0,        32'h0,  0, 1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].instr, vecs[i].pc, vecs[i].br, vecs[i].ill,
                    vecs[i].flush, vecs[i].outReady);
      checkOutput($sformatf("vec%0d.valid", i),   32'(qIf.out_valid),     32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d.instr", i),   qIf.out_instr,          vecs[i].expInstr);
      checkOutput($sformatf("vec%0d.pc", i),      qIf.out_pc,             vecs[i].expPc);
      checkOutput($sformatf("vec%0d.branch", i),  32'(qIf.out_is_branch), 32'(vecs[i].expBr));
      checkOutput($sformatf("vec%0d.illegal", i), 32'(qIf.out_illegal),   32'(vecs[i].expIll));
      checkOutput($sformatf("vec%0d.count", i),   32'(qIf.count),         32'(vecs[i].expCount));
      checkOutput($sformatf("vec%0d.inReady", i), 32'(qIf.in_ready),      32'(vecs[i].expInReady));
    end

    // steady-state streaming at occupancy 2 across several pointer wraps
    applyStimulus(1'b1, TAG | 32'h100, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, TAG | 32'h104, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      driveInputs(1'b1, TAG | (32'h100 + 32'(4 * (k + 2))), 32'h100 + 32'(4 * (k + 2)),
                  1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("wrap%0d.headPc", k), qIf.out_pc, 32'h100 + 32'(4 * k));
      @(posedge clk);
      #1;
      checkOutput($sformatf("wrap%0d.count", k), 32'(qIf.count), 32'h2);
    end
    checkOutput("wrap.finalHead", qIf.out_pc, 32'h150);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("wrap.flushCount", 32'(qIf.count), 32'h0);

    // asynchronous reset between clock edges
    applyStimulus(1'b1, TAG | 32'h200, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, TAG | 32'h204, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, TAG | 32'h208, 32'h208, 1'b0, 1'b0, 1'b0, 1'b0);
    driveInputs(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("areset.preCount", 32'(qIf.count), 32'h3);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("areset.valid",   32'(qIf.out_valid), 32'h0);
    checkOutput("areset.count",   32'(qIf.count),     32'h0);
    checkOutput("areset.inReady", 32'(qIf.in_ready),  32'h1);
    checkOutput("areset.instr",   qIf.out_instr,      32'h0);
    #2;
    reset = 1'b0;
    applyStimulus(1'b1, INSTR_END, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("endMarker.instr", qIf.out_instr,  INSTR_END);
    checkOutput("endMarker.pc",    qIf.out_pc,     32'h300);
    checkOutput("endMarker.count", 32'(qIf.count), 32'h1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    model.delete();

    // randomized traffic against the queue model, alternating drain-heavy and stall-heavy phases
    for (int c = 0; c < 600; c++) begin
      logic        v;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        br;
      logic        ill;
      logic        fl;
      logic        orr;
      v     = ($urandom_range(0, 3) != 0);
      instr = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom | 32'h1);
      pc    = $urandom & 32'hFFFF_FFFC;
      br    = 1'($urandom_range(0, 1));
      ill   = 1'($urandom_range(0, 1));
      fl    = ($urandom_range(0, 24) == 0);
      orr   = ($urandom_range(0, 99) < (((c / 50) % 2 == 0) ? 80 : 25));
      modelStep(v, instr, pc, br, ill, fl, orr);
      applyStimulus(v, instr, pc, br, ill, fl, orr);
      checkAgainstModel($sformatf("rand%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
